// File: rtl/alu_pkg.sv
// alu_multicycle shared definitions: opcodes and FSM states.
// Divider support is selected by the ALU_DIV_EN macro in the top.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_MUL  = 4'b0100;
    localparam logic [3:0] ALU_DIVU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_REMU = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/alu_div_iter.sv
// Restoring unsigned divider datapath, one quotient bit per step.
// Sequencing (load/step timing) is owned by alu_multicycle.
module alu_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quo_nxt_o,
    output logic [WIDTH-1:0] rem_nxt_o
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   shift;
    logic             fits;

    // Quotient register doubles as the dividend shifter, MSB first.
    assign shift     = {rem_q, quo_q[WIDTH-1]};
    assign fits      = shift >= {1'b0, dvs_q};
    assign rem_nxt_o = fits ? (shift[WIDTH-1:0] - dvs_q)
                            : shift[WIDTH-1:0];
    assign quo_nxt_o = {quo_q[WIDTH-2:0], fits};

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
        end else if (step_i) begin
            rem_d = rem_nxt_o;
            quo_d = quo_nxt_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with iterative shift-add multiply and optional divide.
// Define ALU_DIV_EN to build the DIVU/REMU divider path.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             zero_o,
    output logic             overflow_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;

    logic [WIDTH-1:0]   res_sc;
    logic               ovf_sc;
    logic [WIDTH-1:0]   sum, dif;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic               last;

    assign sum  = src1_i + src2_i;
    assign dif  = src1_i - src2_i;
    assign last = cnt_q == LAST;

    // Accumulator is {partial high, unconsumed multiplier bits}.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef ALU_DIV_EN
    logic             rem_sel_q, rem_sel_d;
    logic             div_load, div_step;
    logic [WIDTH-1:0] quo_nxt, rem_nxt;

    alu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (div_load),
        .step_i     (div_step),
        .dividend_i (src1_i),
        .divisor_i  (src2_i),
        .quo_nxt_o  (quo_nxt),
        .rem_nxt_o  (rem_nxt)
    );
`endif

    always_comb begin
        res_sc = '0;
        ovf_sc = 1'b0;
        unique case (ctrl_i)
            ALU_AND:  res_sc = src1_i & src2_i;
            ALU_OR:   res_sc = src1_i | src2_i;
            ALU_XOR:  res_sc = src1_i ^ src2_i;
            ALU_NOR:  res_sc = ~(src1_i | src2_i);
            ALU_ADD: begin
                res_sc = sum;
                ovf_sc = (src1_i[WIDTH-1] == src2_i[WIDTH-1])
                      && (sum[WIDTH-1] != src1_i[WIDTH-1]);
            end
            ALU_SUB: begin
                res_sc = dif;
                ovf_sc = (src1_i[WIDTH-1] != src2_i[WIDTH-1])
                      && (dif[WIDTH-1] != src1_i[WIDTH-1]);
            end
            ALU_SLT:
                res_sc = WIDTH'($signed(src1_i) < $signed(src2_i));
            ALU_SLTU:
                res_sc = WIDTH'(src1_i < src2_i);
            default:  res_sc = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        res_d   = res_q;
        hi_d    = hi_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
`ifdef ALU_DIV_EN
        rem_sel_d = rem_sel_q;
        div_load  = 1'b0;
        div_step  = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    cnt_d = '0;
                    if (ctrl_i == ALU_MUL) begin
                        acc_d   = {{WIDTH{1'b0}}, src2_i};
                        mcand_d = src1_i;
                        state_d = S_MUL;
`ifdef ALU_DIV_EN
                    end else if (ctrl_i == ALU_DIVU
                              || ctrl_i == ALU_REMU) begin
                        rem_sel_d = ctrl_i == ALU_REMU;
                        div_load  = 1'b1;
                        state_d   = S_DIV;
`endif
                    end else begin
                        res_d   = res_sc;
                        hi_d    = '0;
                        zero_d  = res_sc == '0;
                        ovf_d   = ovf_sc;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_nxt;
                if (last) begin
                    res_d   = mul_nxt[WIDTH-1:0];
                    hi_d    = mul_nxt[2*WIDTH-1:WIDTH];
                    zero_d  = mul_nxt[WIDTH-1:0] == '0;
                    ovf_d   = 1'b0;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DIV: begin
`ifdef ALU_DIV_EN
                div_step = 1'b1;
                if (last) begin
                    res_d   = rem_sel_q ? rem_nxt : quo_nxt;
                    hi_d    = '0;
                    zero_d  = (rem_sel_q ? rem_nxt : quo_nxt) == '0;
                    ovf_d   = 1'b0;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef ALU_DIV_EN
            rem_sel_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
`ifdef ALU_DIV_EN
            rem_sel_q <= rem_sel_d;
`endif
        end
    end

    assign ready_o     = state_q == S_IDLE;
    assign valid_o     = valid_q;
    assign result_o    = res_q;
    assign result_hi_o = hi_q;
    assign zero_o      = zero_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (WIDTH=32).
// Expected DIVU/REMU values follow ALU_DIV_EN.
module tb_alu_multicycle;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vin = 1'b0;
    logic          rdy;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [3:0]    op = '0;
    logic          vout;
    logic [W-1:0]  res;
    logic [W-1:0]  hi;
    logic          zf;
    logic          ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (vin),
        .ready_o     (rdy),
        .src1_i      (a),
        .src2_i      (b),
        .ctrl_i      (op),
        .valid_o     (vout),
        .result_o    (res),
        .result_hi_o (hi),
        .zero_o      (zf),
        .overflow_o  (ovf)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, measure accept-to-valid latency, check fields.
    task automatic run_op(input string tag,
                          input logic [3:0] o,
                          input logic [W-1:0] x,
                          input logic [W-1:0] y,
                          input int lat_exp,
                          input logic [W-1:0] r_exp,
                          input logic [W-1:0] h_exp,
                          input logic z_exp,
                          input logic v_exp);
        int lat;
        bit rdy_seen;
        chk({tag, ".rdy0"}, 64'(rdy), 64'd1);
        op = o; a = x; b = y; vin = 1'b1;
        tick();
        vin = 1'b0;
        lat = 0;
        rdy_seen = 1'b0;
        while (!vout && lat < 100) begin
            if (rdy) rdy_seen = 1'b1;
            tick();
            lat++;
        end
        chk({tag, ".lat"}, 64'(lat), 64'(lat_exp));
        chk({tag, ".busy"}, 64'(rdy_seen), 64'd0);
        chk({tag, ".res"}, 64'(res), 64'(r_exp));
        chk({tag, ".hi"}, 64'(hi), 64'(h_exp));
        chk({tag, ".zero"}, 64'(zf), 64'(z_exp));
        chk({tag, ".ovf"}, 64'(ovf), 64'(v_exp));
        tick();
        chk({tag, ".vpulse"}, 64'(vout), 64'd0);
        chk({tag, ".rdy1"}, 64'(rdy), 64'd1);
        chk({tag, ".hold"}, 64'(res), 64'(r_exp));
    endtask

    initial begin
        int pulses;
        int dl;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst.ready", 64'(rdy), 64'd1);
        chk("rst.valid", 64'(vout), 64'd0);
        chk("rst.res", 64'(res), 64'd0);
        chk("rst.hi", 64'(hi), 64'd0);
        chk("rst.zero", 64'(zf), 64'd1);
        chk("rst.ovf", 64'(ovf), 64'd0);

        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1,
               0, 32'h8000_0000, 0, 1'b0, 1'b1);
        run_op("sub_zero", 4'b0110, 32'd5, 32'd5,
               0, 32'h0, 0, 1'b1, 1'b0);
        run_op("slt", 4'b0111, 32'hFFFF_FFFF, 32'h1,
               0, 32'h1, 0, 1'b0, 1'b0);
        run_op("sltu", 4'b1000, 32'hFFFF_FFFF, 32'h1,
               0, 32'h0, 0, 1'b1, 1'b0);
        run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h1,
               0, 32'h7FFF_FFFF, 0, 1'b0, 1'b1);
        run_op("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00,
               0, 32'h00F0_1200, 0, 1'b0, 1'b0);
        run_op("or", 4'b0001, 32'hF000_0001, 32'h0000_0F00,
               0, 32'hF000_0F01, 0, 1'b0, 1'b0);
        run_op("xor", 4'b0011, 32'hAAAA_5555, 32'hFFFF_0000,
               0, 32'h5555_5555, 0, 1'b0, 1'b0);
        run_op("nor", 4'b1100, 32'hFFFF_0000, 32'h0000_00FF,
               0, 32'h0000_FF00, 0, 1'b0, 1'b0);
        run_op("undef", 4'b1111, 32'h1234, 32'h5678,
               0, 32'h0, 0, 1'b1, 1'b0);
        run_op("mul_max", 4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               W, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("mul_small", 4'b0100, 32'd3, 32'd5,
               W, 32'd15, 32'd0, 1'b0, 1'b0);
        run_op("add_after_mul", 4'b0010, 32'd1, 32'd1,
               0, 32'd2, 0, 1'b0, 1'b0);
`ifdef ALU_DIV_EN
        run_op("divu", 4'b0101, 32'd100, 32'd7,
               W, 32'd14, 0, 1'b0, 1'b0);
        run_op("remu", 4'b1101, 32'd100, 32'd7,
               W, 32'd2, 0, 1'b0, 1'b0);
        run_op("divu0", 4'b0101, 32'd9, 32'd0,
               W, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        run_op("remu0", 4'b1101, 32'd9, 32'd0,
               W, 32'd9, 0, 1'b0, 1'b0);
        run_op("divu_big", 4'b0101, 32'hFFFF_FFFF, 32'h8000_0001,
               W, 32'd1, 0, 1'b0, 1'b0);
`else
        run_op("divu", 4'b0101, 32'd100, 32'd7,
               0, 32'd0, 0, 1'b1, 1'b0);
        run_op("remu", 4'b1101, 32'd100, 32'd7,
               0, 32'd0, 0, 1'b1, 1'b0);
`endif

        // Reset in the middle of a multiply aborts it.
        op = 4'b0100; a = 32'd7; b = 32'd9; vin = 1'b1;
        tick();
        vin = 1'b0;
        repeat (10) tick();
        chk("abort.busy", 64'(rdy), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.ready", 64'(rdy), 64'd1);
        chk("abort.res", 64'(res), 64'd0);
        chk("abort.zero", 64'(zf), 64'd1);
        pulses = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (vout) pulses++;
            tick();
        end
        chk("abort.nopulse", 64'(pulses), 64'd0);

        // Reset and request together: request dropped.
        op = 4'b0010; a = 32'd4; b = 32'd4; vin = 1'b1; rst = 1'b1;
        tick();
        vin = 1'b0; rst = 1'b0;
        chk("rstreq.valid", 64'(vout), 64'd0);
        chk("rstreq.ready", 64'(rdy), 64'd1);
        tick();
        chk("rstreq.valid2", 64'(vout), 64'd0);

        // Request held high through a multiply, then retargeted.
        op = 4'b0100; a = 32'd6; b = 32'd7; vin = 1'b1;
        tick();
        op = 4'b0010; a = 32'd1; b = 32'd2;
        pulses = 0;
        dl = 0;
        while (!vout && dl < 100) begin
            tick();
            dl++;
        end
        chk("held.lat", 64'(dl), 64'(W));
        chk("held.mulres", 64'(res), 64'd42);
        if (vout) pulses++;
        tick();
        if (vout) pulses++;
        chk("held.onepulse", 64'(pulses), 64'd1);
        chk("held.idle", 64'(rdy), 64'd1);
        tick();
        vin = 1'b0;
        chk("held.addv", 64'(vout), 64'd1);
        chk("held.addres", 64'(res), 64'd3);
        chk("held.addhi", 64'(hi), 64'd0);
        tick();
        chk("held.end", 64'(vout), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, registered successor to the single-cycle datapath ALU. Single-cycle logic/arithmetic ops return one cycle after acceptance; multiply (and optionally divide) run as iterative shift-add / restoring-divide sequences over WIDTH cycles, with a valid/ready handshake to the issuing pipeline stage. Sits in the EX stage of the multi-cycle CPU and stalls issue via ready_o.

## Interface
- WIDTH, 32, operand/result width in bits (≥4)
- clk_i  input  1  clock, all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- valid_i  input  1  operation request
- ready_o  output  1  block can accept a request this cycle
- src1_i  input  WIDTH  operand A
- src2_i  input  WIDTH  operand B
- ctrl_i  input  4  operation code
- valid_o  output  1  one-cycle pulse, result fields valid
- result_o  output  WIDTH  result (MUL: low half; DIV: quotient; REM: remainder)
- result_hi_o  output  WIDTH  MUL high half; 0 for all other ops
- zero_o  output  1  result_o == 0
- overflow_o  output  1  signed overflow for ADD/SUB; 0 otherwise

## Operation
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1100 NOR, 0011 XOR, 1000 SLTU (unsigned), 0100 MUL (unsigned, 2·WIDTH product), 0101 DIVU, 1101 REMU; any other code: result 0, single-cycle.
- Accept when valid_i && ready_o; operands and ctrl latched on that edge. valid_i while ready_o=0 is ignored (not queued).
- FSM: IDLE → (single-cycle op) DONE; IDLE → (MUL) MUL; IDLE → (DIVU/REMU) DIV; MUL/DIV → DONE after WIDTH iterations; DONE → IDLE.
- ready_o = 1 only in IDLE. valid_o = 1 only in DONE.
- MUL: shift-add, one multiplier bit per cycle, LSB first; 2·WIDTH accumulator.
- DIVU/REMU: restoring division, one quotient bit per cycle, MSB first.
- Divide by zero: quotient = all ones, remainder = src1; no exception.
- Overflow: ADD when operands same sign and sum sign differs; SUB when operand signs differ and result sign differs from src1.
- Result fields hold their value after the valid_o pulse until the next DONE.

## Timing
- Reset: state IDLE, ready_o 1, valid_o 0, result_o 0, result_hi_o 0, zero_o 1, overflow_o 0, iteration counter 0.
- Single-cycle ops: accept at edge N, valid_o high in cycle N+1, ready_o again in N+2.
- MUL/DIVU/REMU: accept at edge N, valid_o in cycle N+WIDTH+1, ready_o in N+WIDTH+2.
- Iteration counter: $clog2(WIDTH)+1 bits, counts 0..WIDTH-1, no wrap beyond.
- rst_i mid-operation: abort on that edge, all outputs return to reset values, partial result discarded; no valid_o for the aborted op.
- rst_i and valid_i in the same cycle: reset wins, request dropped.
- Back-to-back: new request earliest in the cycle after DONE (one bubble per op).

## Configuration
- ALU_DIV_EN defined: DIV state and divider present; 0101/1101 behave as above.
- ALU_DIV_EN undefined: divider not compiled; 0101/1101 fall into the default path (result 0, single-cycle, zero_o 1).

## Structure
- Package alu_pkg: 4-bit opcode localparams (ALU_AND … ALU_REMU), FSM state enum (S_IDLE, S_MUL, S_DIV, S_DONE).
- Sub-module alu_div_iter: restoring divider datapath (remainder/quotient registers, step enable, load), instantiated only under ALU_DIV_EN; FSM and counter stay in alu_multicycle.

## Test plan
- Reset then ADD 0x7FFFFFFF + 1 (WIDTH=32) -> valid_o one cycle later, result_o 0x80000000, overflow_o 1, zero_o 0.
- SUB 5 − 5, then SLT 0xFFFFFFFF vs 1, then SLTU same -> results 0 (zero_o 1), 1, 0 respectively, each 1-cycle latency.
- MUL 0xFFFFFFFF × 0xFFFFFFFF -> valid_o at cycle 33 after accept, result_hi_o 0xFFFFFFFE, result_o 0x00000001; ready_o low throughout.
- DIVU 100 / 7 and REMU 100 / 7 -> 14 and 2; DIVU 9 / 0 -> 0xFFFFFFFF, REMU 9 / 0 -> 9 (ALU_DIV_EN only; without it both return 0).
- MUL started, rst_i asserted at iteration 10 -> next cycle IDLE, ready_o 1, result_o 0, no valid_o pulse.
- valid_i held high during MUL with a different op -> ignored; exactly one valid_o for the MUL, then the held request accepted in IDLE.
